// File: rtl/gerador_janela.sv
// gerador_janela -- 3x3 sliding-window generator for the Sobel stage.
//
// Takes a raster-order 8-bit grayscale stream, keeps the two previous rows
// in line buffers and emits every fully interior 3x3 neighbourhood as three
// 24-bit row words. No padding: (IMG_W-2)*(IMG_H-2) windows per frame.
//
// Parameters:
//   IMG_W        image width in pixels (>=3)
//   IMG_H        image height in pixels (>=3)
//
// Ports:
//   clk          clock, all logic on posedge
//   rst          synchronous reset, active low (0 = reset)
//   pixel_in     input pixel, unsigned
//   pixel_valid  pixel_in holds a valid pixel
//   pixel_ready  block can accept a pixel this cycle (combinational)
//   linha1       top window row    {left, centre, right}
//   linha2       middle window row {left, centre, right}
//   linha3       bottom window row {left, centre, right}
//   janela_valid linha1..3 hold a valid window
//   janela_ready downstream takes the window this cycle
//   frame_done   one-cycle pulse, the cycle after the last window of a
//                frame is handed off
//   janelas_cnt  (only with JANELA_CNT_EN) windows handed off this frame
//
// Optional feature macro: JANELA_CNT_EN adds the janelas_cnt output.

module gerador_janela #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pixel_in,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  output logic [23:0] linha1,
  output logic [23:0] linha2,
  output logic [23:0] linha3,
  output logic        janela_valid,
  input  logic        janela_ready,
  output logic        frame_done
`ifdef JANELA_CNT_EN
  ,
  output logic [15:0] janelas_cnt
`endif
);

  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 2;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 2;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  typedef enum logic [1:0] {
    PREENCHE,
    PROCESSA,
    FIM
  } estado_t;

  estado_t       state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  // lb1 = previous row, lb2 = the row before it. Never reset: every entry
  // is rewritten before the window logic can look at it.
  logic [7:0]    lb1 [IMG_W];
  logic [7:0]    lb2 [IMG_W];

  // Two older window columns per row; the newest column comes straight
  // from the line buffers and pixel_in.
  logic [15:0]   sr_top, sr_mid, sr_bot;

  logic [7:0]    top_px, mid_px;
  logic          accept, handoff, emit, frame_end_px;
  logic          last_pend;

  assign pixel_ready  = rst && (!janela_valid || janela_ready);
  assign accept       = pixel_valid && pixel_ready;
  assign handoff      = janela_valid && janela_ready;
  assign top_px       = lb2[col];
  assign mid_px       = lb1[col];
  assign emit         = accept && (row >= ROW_TWO) && (col >= COL_TWO);
  assign frame_end_px = (col == COL_LAST) && (row == ROW_LAST);

  // Datapath storage without reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2[col] <= mid_px;
      lb1[col] <= pixel_in;
      // Keeps shifting across row boundaries; emit is gated at cols 0/1 so
      // a window never mixes the end of one row with the start of the next.
      sr_top   <= {sr_top[7:0], top_px};
      sr_mid   <= {sr_mid[7:0], mid_px};
      sr_bot   <= {sr_bot[7:0], pixel_in};
    end
  end

  // Counters, output register and frame FSM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      col          <= '0;
      row          <= '0;
      state        <= PREENCHE;
      janela_valid <= 1'b0;
      frame_done   <= 1'b0;
      linha1       <= 24'h000000;
      linha2       <= 24'h000000;
      linha3       <= 24'h000000;
      last_pend    <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (accept) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end

      // Single output stage: a new window may replace the one being handed
      // off in the same cycle, giving one window per cycle.
      if (emit) begin
        linha1       <= {sr_top, top_px};
        linha2       <= {sr_mid, mid_px};
        linha3       <= {sr_bot, pixel_in};
        janela_valid <= 1'b1;
        last_pend    <= frame_end_px;
      end else if (handoff) begin
        janela_valid <= 1'b0;
        last_pend    <= 1'b0;
      end

      case (state)
        FIM: begin
          state <= emit ? PROCESSA : PREENCHE;
        end
        default: begin
          // The bottom-right window leaving ends the frame, even if pixel 0
          // of the next frame is accepted in the same cycle.
          if (handoff && last_pend) begin
            state      <= FIM;
            frame_done <= 1'b1;
          end else if (accept) begin
            state <= emit ? PROCESSA : PREENCHE;
          end
        end
      endcase
    end
  end

`ifdef JANELA_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      janelas_cnt <= 16'd0;
    end else if (frame_done) begin
      janelas_cnt <= 16'd0;
    end else if (handoff) begin
      janelas_cnt <= janelas_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/gerador_janela.md
Name: gerador_janela

Overview:
- Upstream neighbour of the Sobel convolution stage.
- Accepts a raster-order 8-bit grayscale pixel stream, one pixel per handshake.
- Buffers the two previous image rows and emits every complete 3x3 neighbourhood as three 24-bit row words (linha1/linha2/linha3) with a valid/ready handshake.
- No padding: only fully interior windows are produced, (IMG_W-2)*(IMG_H-2) per frame.

Parameters:
- IMG_W, 64: image width in pixels (>=3).
- IMG_H, 64: image height in pixels (>=3).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset; synchronous, active-low (0 = reset).
- pixel_in  input  8  input pixel, unsigned.
- pixel_valid  input  1  pixel_in holds a valid pixel.
- pixel_ready  output  1  block can accept a pixel this cycle.
- linha1  output  24  top window row; [23:16] left, [15:8] centre, [7:0] right.
- linha2  output  24  middle window row, same packing.
- linha3  output  24  bottom window row, same packing.
- janela_valid  output  1  linha1..3 hold a valid window.
- janela_ready  input  1  downstream accepts the window this cycle.
- frame_done  output  1  one-cycle pulse when the last window of a frame is accepted.

Behaviour:
- Pixel accept when pixel_valid && pixel_ready.
- pixel_ready = rst && (!janela_valid || janela_ready). Combinational; single output register stage.
- Counters col (0..IMG_W-1) and row (0..IMG_H-1):
  - Advance on each accept.
  - col wraps to 0 and row increments after IMG_W-1.
  - Both return to 0 after the last pixel (row IMG_H-1, col IMG_W-1).
- Two line buffers of IMG_W bytes: lb1 holds row-1, lb2 holds row-2. On accept at column c:
  - lb2[c] <= lb1[c]
  - lb1[c] <= pixel_in
  - Window shift registers shift left by one column; new right column = {lb2[c], lb1[c], pixel_in} (top, mid, bottom).
- Window emit: if the accepted pixel has row>=2 and col>=2, the next cycle shows janela_valid=1 with linha1..3 = the 3x3 window ending at that pixel. Latency is 1 cycle from accept.
  - The shift registers keep shifting at col 0/1, but no window is flagged there, so windows never mix row ends.
- Hold rule: while janela_valid && !janela_ready, linha1..3 and janela_valid stay stable and no pixel is accepted.
  - janela_valid clears on handoff unless a new window is produced in the same cycle.
- States:
  - PREENCHE: rows 0-1, plus cols 0-1 of each later row. No output.
  - PROCESSA: windows emitted.
  - FIM: one cycle with frame_done=1, entered when the last window (bottom-right) is handed off. Then back to PREENCHE with counters at 0.
  - Pixels for the next frame may be accepted during FIM.
- Simultaneous handoff and new window production in one cycle is legal. Full throughput is 1 window/cycle.
- Gaps in pixel_valid stall everything; no state changes without an accept.
- Reset (rst=0 at a clock edge, including mid-frame):
  - col, row = 0; state PREENCHE.
  - janela_valid = 0, frame_done = 0, linha1..3 = 24'h000000.
  - pixel_ready = 0 while rst=0.
  - Line buffer contents are not cleared; they are never observed before being rewritten.
- No arithmetic beyond counters; pixels pass unmodified.

Optional Feature:
- Macro: JANELA_CNT_EN.
- When defined:
  - Adds output janelas_cnt [15:0], the count of windows handed off in the current frame.
  - Increments on each janela_valid && janela_ready.
  - Clears to 0 on reset and on the cycle after frame_done.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- IMG_W=4, IMG_H=4, pixels 0x00..0x0F streamed back-to-back, janela_ready=1 -> windows in order:
  - {000102,040506,08090A}
  - {010203,050607,090A0B}
  - {040506,08090A,0C0D0E}
  - {050607,090A0B,0D0E0F}
  - First window appears the cycle after pixel 0x0A is accepted; frame_done pulses with the 4th handoff.
- Same stream with janela_ready=0 for 5 cycles while the first window is valid -> window stays {000102,040506,08090A}, pixel_ready=0, pixel 0x0B not accepted until the handoff.
- Random pixel_valid gaps (50%) -> identical window sequence and count 4; no duplicated or skipped windows.
- rst=0 for one cycle after pixel 0x09 -> all outputs 0. A fresh 16-pixel frame then yields exactly the 4 windows above.
- Two frames back-to-back (second frame = 0x10..0x1F) -> 8 windows; the first window of frame 2 is {101112,141516,18191A}; two frame_done pulses.
- With JANELA_CNT_EN defined -> janelas_cnt reads 1,2,3,4 after each handoff, then 0 after frame_done.
